// File: rtl/glitch_pulse_gen.sv
// Purpose : armed trigger -> programmable delay -> programmable-width pulse, register-bus configured.
// Latency : pulse active from t3+DELAY after trig_in is first sampled at t0; reg_data_out valid 1 cycle after address settles.
// Backpres: none; triggers arriving while DELAY/PULSE are busy are dropped and flagged as missed.
// Ports   : clkin/reset (async active-low), trig_in (async), reg_* register bus from cmd_handler,
//           pulse_out (registered, polarity via CTRL.invert), armed/busy state indicators.
module glitch_pulse_gen #(
    parameter logic [7:0] ADDR_DELAY  = 8'h20,
    parameter logic [7:0] ADDR_WIDTH  = 8'h21,
    parameter logic [7:0] ADDR_CTRL   = 8'h22,
    parameter logic [7:0] ADDR_STATUS = 8'h23,
    parameter int         DELAY_W     = 32,
    parameter int         WIDTH_W     = 16
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        trig_in,
    input  logic [7:0]  reg_cmd,
    input  logic [15:0] reg_bytecount,
    input  logic [7:0]  reg_data_in,
    input  logic        reg_write,
    input  logic        reg_read,
    output logic [7:0]  reg_data_out,
    output logic        pulse_out,
    output logic        armed,
    output logic        busy
);

    localparam int DELAY_BYTES = DELAY_W / 8;
    localparam int WIDTH_BYTES = WIDTH_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DELAY, S_PULSE} state_t;

    state_t               state;
    logic [DELAY_W-1:0]   delay_reg;
    logic [WIDTH_W-1:0]   width_reg;
    logic [DELAY_W-1:0]   dcnt;
    logic [WIDTH_W-1:0]   wcnt;
    logic [2:0]           ctrl;        // {invert, continuous, arm}
    logic                 fired;
    logic                 missed;
    logic [7:0]           fire_count;
    logic                 s1, s2, s3;
    logic                 rise;
    logic                 ctrl_wr;
    logic                 status_clr;
    logic [7:0]           status;
    logic [7:0]           rd_byte;

    assign armed      = (state == S_ARMED);
    assign busy       = (state == S_DELAY) || (state == S_PULSE);
    assign rise       = s2 & ~s3;
    assign ctrl_wr    = reg_write && (reg_cmd == ADDR_CTRL) && (reg_bytecount == 16'd0);
    assign status_clr = reg_read && (reg_cmd == ADDR_STATUS);
    assign status     = {fire_count[3:0], missed, fired, busy, armed};

    // Two flops for metastability, the third only for edge detection.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= trig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (reg_cmd)
            ADDR_DELAY: begin
                for (int i = 0; i < DELAY_BYTES; i++)
                    if (reg_bytecount == 16'(i)) rd_byte = delay_reg[i*8 +: 8];
            end
            ADDR_WIDTH: begin
                for (int i = 0; i < WIDTH_BYTES; i++)
                    if (reg_bytecount == 16'(i)) rd_byte = width_reg[i*8 +: 8];
            end
            ADDR_CTRL:   if (reg_bytecount == 16'd0) rd_byte = {5'b0, ctrl};
            ADDR_STATUS: if (reg_bytecount == 16'd0) rd_byte = status;
            default:     rd_byte = 8'h00;
        endcase
    end

    // Timing registers and read-back path.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            delay_reg    <= '0;
            width_reg    <= WIDTH_W'(1);
            reg_data_out <= 8'h00;
        end else begin
            reg_data_out <= rd_byte;
            if (reg_write && reg_cmd == ADDR_DELAY) begin
                for (int i = 0; i < DELAY_BYTES; i++)
                    if (reg_bytecount == 16'(i)) delay_reg[i*8 +: 8] <= reg_data_in;
            end
            if (reg_write && reg_cmd == ADDR_WIDTH) begin
                for (int i = 0; i < WIDTH_BYTES; i++)
                    if (reg_bytecount == 16'(i)) width_reg[i*8 +: 8] <= reg_data_in;
            end
        end
    end

    // Control register, status flags and the pulse FSM share one block because
    // a one-shot pulse end clears CTRL.arm in the same edge it leaves PULSE.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ctrl       <= 3'b000;
            fired      <= 1'b0;
            missed     <= 1'b0;
            fire_count <= 8'h00;
            dcnt       <= '0;
            wcnt       <= '0;
            pulse_out  <= 1'b0;
        end else begin
            // Hold level; transitions below override it. Using the current ctrl
            // makes a new idle polarity show up one edge after the CTRL write.
            pulse_out <= (state == S_PULSE) ^ ctrl[2];

            // Clear first so a set event in the same cycle wins.
            if (status_clr) begin
                fired  <= 1'b0;
                missed <= 1'b0;
            end

            if (state != S_IDLE && !ctrl[0]) begin
                // Abort: no fired/count update.
                state     <= S_IDLE;
                pulse_out <= ctrl[2];
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ctrl[0]) state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (rise) begin
                            state <= S_DELAY;
                            dcnt  <= delay_reg;
                            wcnt  <= (width_reg == '0) ? WIDTH_W'(1) : width_reg;
                        end
                    end
                    S_DELAY: begin
                        if (rise) missed <= 1'b1;
                        if (dcnt == '0) begin
                            state     <= S_PULSE;
                            pulse_out <= ~ctrl[2];
                        end else begin
                            dcnt <= dcnt - DELAY_W'(1);
                        end
                    end
                    S_PULSE: begin
                        if (rise) missed <= 1'b1;
                        if (wcnt == WIDTH_W'(1)) begin
                            pulse_out  <= ctrl[2];
                            fired      <= 1'b1;
                            fire_count <= fire_count + 8'd1;
                            if (ctrl[1]) begin
                                state <= S_ARMED;
                            end else begin
                                state   <= S_IDLE;
                                ctrl[0] <= 1'b0;
                            end
                        end else begin
                            wcnt <= wcnt - WIDTH_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end

            // A register write lands last so it takes priority over the auto-disarm.
            if (ctrl_wr) ctrl <= reg_data_in[2:0];
        end
    end

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Purpose : directed check of glitch_pulse_gen register map, pulse timing, sticky status and abort.
// Latency : n/a (bench); inputs driven at negedge, outputs sampled at negedge or #1 after posedge.
// Backpres: n/a; every wait is a fixed cycle count.
module tb_glitch_pulse_gen;

    logic        clkin = 1'b0;
    logic        reset = 1'b0;
    logic        trig_in = 1'b0;
    logic [7:0]  reg_cmd = 8'h00;
    logic [15:0] reg_bytecount = 16'h0000;
    logic [7:0]  reg_data_in = 8'h00;
    logic        reg_write = 1'b0;
    logic        reg_read = 1'b0;
    logic [7:0]  reg_data_out;
    logic        pulse_out;
    logic        armed;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clkin = ~clkin;

    glitch_pulse_gen dut (
        .clkin         (clkin),
        .reset         (reset),
        .trig_in       (trig_in),
        .reg_cmd       (reg_cmd),
        .reg_bytecount (reg_bytecount),
        .reg_data_in   (reg_data_in),
        .reg_write     (reg_write),
        .reg_read      (reg_read),
        .reg_data_out  (reg_data_out),
        .pulse_out     (pulse_out),
        .armed         (armed),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All register tasks start at a negedge and return at the next negedge.
    task automatic wr(input logic [7:0] cmd, input logic [15:0] bc, input logic [7:0] d);
        reg_cmd = cmd; reg_bytecount = bc; reg_data_in = d; reg_write = 1'b1;
        @(negedge clkin);
        reg_write = 1'b0;
    endtask

    task automatic rd(input logic [7:0] cmd, input logic [15:0] bc, output logic [7:0] d);
        reg_cmd = cmd; reg_bytecount = bc; reg_read = 1'b1;
        @(negedge clkin);
        reg_read = 1'b0;
        d = reg_data_out;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] cmd, input logic [15:0] bc,
                            input logic [7:0] exp);
        logic [7:0] d;
        rd(cmd, bc, d);
        check(tag, {24'h0, d}, {24'h0, exp});
    endtask

    // Raise trig_in just before edge t0, then sample pulse_out #1 after each edge t_k.
    // Reports first k where pulse_out is at level lvl and the number of such k.
    task automatic fire(input int n, input logic lvl, input int retrig,
                        output int first, output int width);
        first = -1;
        width = 0;
        trig_in = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clkin);
            #1;
            if (pulse_out == lvl) begin
                if (first < 0) first = k;
                width++;
            end
            if (k == 3) trig_in = 1'b0;
            if (k == retrig) trig_in = 1'b1;
        end
        trig_in = 1'b0;
        @(negedge clkin);
    endtask

    initial begin
        int first, width, lows;

        // Reset state
        repeat (3) @(negedge clkin);
        check("rst_pulse", {31'h0, pulse_out}, 0);
        check("rst_armed", {31'h0, armed}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_rdata", {24'h0, reg_data_out}, 0);
        reset = 1'b1;
        @(negedge clkin);
        rd_check("rst_width_b0", 8'h21, 0, 8'h01);
        rd_check("rst_ctrl", 8'h22, 0, 8'h00);
        rd_check("rst_status", 8'h23, 0, 8'h00);

        // One-shot: DELAY=5, WIDTH=3 -> high after t8..t10
        wr(8'h20, 0, 8'h05);
        wr(8'h21, 0, 8'h03);
        wr(8'h22, 0, 8'h01);
        @(negedge clkin);
        check("t1_armed", {31'h0, armed}, 1);
        fire(20, 1'b1, -1, first, width);
        check("t1_first", first, 8);
        check("t1_width", width, 3);
        check("t1_armed_after", {31'h0, armed}, 0);
        rd_check("t1_status", 8'h23, 0, 8'h14);
        rd_check("t1_ctrl_disarmed", 8'h22, 0, 8'h00);
        rd_check("t1_status_clr", 8'h23, 0, 8'h10);

        // Continuous: DELAY=256, WIDTH=0 (treated as 1)
        wr(8'h20, 0, 8'h00);
        wr(8'h20, 1, 8'h01);
        wr(8'h20, 2, 8'h00);
        wr(8'h20, 3, 8'h00);
        wr(8'h21, 0, 8'h00);
        wr(8'h21, 1, 8'h00);
        wr(8'h22, 0, 8'h03);
        repeat (2) @(negedge clkin);
        rd_check("t2_delay_b1", 8'h20, 1, 8'h01);
        fire(400, 1'b1, -1, first, width);
        check("t2_first", first, 259);
        check("t2_width", width, 1);
        check("t2_armed", {31'h0, armed}, 1);
        rd_check("t2_status", 8'h23, 0, 8'h25);

        // Second trigger with a retrigger during DELAY -> missed
        fire(400, 1'b1, 50, first, width);
        check("t3_first", first, 259);
        check("t3_width", width, 1);
        check("t3_armed", {31'h0, armed}, 1);
        rd_check("t3_status", 8'h23, 0, 8'h3D);
        rd_check("t3_status_clr", 8'h23, 0, 8'h31);

        // Invert: idle high, low pulse; DELAY=10, WIDTH=2, one-shot
        wr(8'h22, 0, 8'h05);
        repeat (2) @(negedge clkin);
        check("t4_idle_inv", {31'h0, pulse_out}, 1);
        wr(8'h20, 1, 8'h00);
        wr(8'h20, 0, 8'h0A);
        wr(8'h21, 0, 8'h02);
        fire(40, 1'b0, -1, first, width);
        check("t4_first", first, 13);
        check("t4_width", width, 2);
        check("t4_idle_after", {31'h0, pulse_out}, 1);
        rd_check("t4_status", 8'h23, 0, 8'h44);

        // Abort mid-DELAY by clearing arm, invert kept
        wr(8'h20, 0, 8'h00);
        wr(8'h20, 1, 8'h01);
        wr(8'h22, 0, 8'h05);
        repeat (2) @(negedge clkin);
        trig_in = 1'b1;
        repeat (4) @(negedge clkin);
        trig_in = 1'b0;
        repeat (20) @(negedge clkin);
        check("t5_busy", {31'h0, busy}, 1);
        wr(8'h22, 0, 8'h04);
        lows = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clkin);
            if (pulse_out == 1'b0) lows++;
        end
        check("t5_no_pulse", lows, 0);
        check("t5_busy_after", {31'h0, busy}, 0);
        check("t5_armed_after", {31'h0, armed}, 0);
        rd_check("t5_status", 8'h23, 0, 8'h40);

        // Out-of-range byte, unknown address, read-only status, reserved bits
        wr(8'h20, 4, 8'hAA);
        wr(8'h7F, 0, 8'h55);
        wr(8'h23, 0, 8'hFF);
        rd_check("t6_delay_b0", 8'h20, 0, 8'h00);
        rd_check("t6_delay_b1", 8'h20, 1, 8'h01);
        rd_check("t6_delay_b4", 8'h20, 4, 8'h00);
        rd_check("t6_unmapped", 8'h7F, 0, 8'h00);
        rd_check("t6_width_b2", 8'h21, 2, 8'h00);
        rd_check("t6_status", 8'h23, 0, 8'h40);
        wr(8'h22, 0, 8'hF8);
        rd_check("t6_ctrl_rsvd", 8'h22, 0, 8'h00);

        // Asynchronous reset in the middle of a pulse
        wr(8'h20, 1, 8'h00);
        wr(8'h21, 0, 8'h20);
        wr(8'h22, 0, 8'h01);
        repeat (2) @(negedge clkin);
        trig_in = 1'b1;
        repeat (8) @(negedge clkin);
        check("t7_pulse_high", {31'h0, pulse_out}, 1);
        #1 reset = 1'b0;
        #1;
        check("t7_async_drop", {31'h0, pulse_out}, 0);
        check("t7_async_busy", {31'h0, busy}, 0);
        trig_in = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
